// File: rtl/mem_write_arbiter_if.sv
// Write-request bundle between the two write sources, the arbiter and the
// memory controller. The arbiter takes the slave side.
interface mem_write_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128,
  parameter int MASK_W = DATA_W / 8,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  // Framebuffer source
  logic              fb_valid;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic [MASK_W-1:0] fb_mask;

  // BVH builder source
  logic              bvh_valid;
  logic              bvh_ready;
  logic [ADDR_W-1:0] bvh_addr;
  logic [DATA_W-1:0] bvh_data;
  logic [MASK_W-1:0] bvh_mask;

  // Memory controller write port
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic [MASK_W-1:0] mc_mask;
  logic              mc_src;

  // Status
  logic [LVL_W-1:0]  fb_level;
  logic [LVL_W-1:0]  bvh_level;
  logic              idle;

  modport slave (
    input  fb_valid, fb_addr, fb_data, fb_mask,
    input  bvh_valid, bvh_addr, bvh_data, bvh_mask,
    input  mc_ready,
    output fb_ready, bvh_ready,
    output mc_valid, mc_addr, mc_data, mc_mask, mc_src,
    output fb_level, bvh_level, idle
  );

  modport master (
    output fb_valid, fb_addr, fb_data, fb_mask,
    output bvh_valid, bvh_addr, bvh_data, bvh_mask,
    output mc_ready,
    input  fb_ready, bvh_ready,
    input  mc_valid, mc_addr, mc_data, mc_mask, mc_src,
    input  fb_level, bvh_level, idle
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Merges the framebuffer and BVH write streams into one memory-controller
// write port: a FIFO per source, round-robin arbitration, and a single
// registered output slot. Source index 0 = FB, 1 = BVH (matches mc_src).
module mem_write_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128,
  parameter int MASK_W = DATA_W / 8,
  parameter int DEPTH  = 8
) (
  input logic                clk,
  input logic                resetn,
  mem_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W + MASK_W;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } slot_state_e;

  logic [ENT_W-1:0] w_in_entry   [2];
  logic [1:0]       w_in_valid;
  logic [ENT_W-1:0] r_mem        [2][DEPTH];
  logic [PTR_W-1:0] r_wr_ptr     [2];
  logic [PTR_W-1:0] r_rd_ptr     [2];
  logic [LVL_W-1:0] r_level      [2];
  logic [LVL_W-1:0] w_level_next [2];
  logic [1:0]       r_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_nonempty;

  slot_state_e      r_state;
  slot_state_e      w_state_next;
  logic [ENT_W-1:0] r_payload;
  logic             r_src;
  logic             r_last;
  logic             w_grant;
  logic             w_load;

  assign w_in_valid    = {bus.bvh_valid, bus.fb_valid};
  assign w_in_entry[0] = {bus.fb_addr, bus.fb_data, bus.fb_mask};
  assign w_in_entry[1] = {bus.bvh_addr, bus.bvh_data, bus.bvh_mask};

  // Push qualification and occupancy flags, from registered state only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_push     = '0;
    w_nonempty = '0;
    for (int s = 0; s < 2; s++) begin
      w_push[s]     = w_in_valid[s] && r_ready[s];
      w_nonempty[s] = (r_level[s] != '0);
    end
  end

  // Round-robin grant and output-slot next state.
  always_comb begin
    w_grant = w_nonempty[1];
    if (&w_nonempty) begin
      w_grant = ~r_last;
    end
    w_load       = (|w_nonempty) && ((r_state == S_EMPTY) || bus.mc_ready);
    w_state_next = r_state;
    if (w_load) begin
      w_state_next = S_HOLD;
    end else if (bus.mc_ready) begin
      w_state_next = S_EMPTY;
    end
  end

  // Pop of the granted FIFO and resulting occupancy.
  always_comb begin
    w_pop = '0;
    for (int s = 0; s < 2; s++) begin
      w_pop[s]        = w_load && (w_grant == 1'(s));
      w_level_next[s] = r_level[s];
      case ({w_push[s], w_pop[s]})
        2'b10:   w_level_next[s] = r_level[s] + LVL_W'(1);
        2'b01:   w_level_next[s] = r_level[s] - LVL_W'(1);
        default: w_level_next[s] = r_level[s];
      endcase
    end
  end

  // FIFO pointers, levels and registered ready; ready is refused while full
  // even if a pop frees a slot this cycle, so it never depends on mc_ready.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!resetn) begin
      for (int s = 0; s < 2; s++) begin
        r_wr_ptr[s] <= '0;
        r_rd_ptr[s] <= '0;
        r_level[s]  <= '0;
      end
      r_ready <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) r_wr_ptr[s] <= r_wr_ptr[s] + PTR_W'(1);
        if (w_pop[s])  r_rd_ptr[s] <= r_rd_ptr[s] + PTR_W'(1);
        r_level[s] <= w_level_next[s];
        r_ready[s] <= (w_level_next[s] < LVL_W'(DEPTH));
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; levels and pointers reset, so stale entries are never read.
    for (int s = 0; s < 2; s++) begin
      if (w_push[s]) r_mem[s][r_wr_ptr[s]] <= w_in_entry[s];
    end
  end

  // Output slot state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_EMPTY;
    else         r_state <= w_state_next;
  end

  // Output payload, source tag and round-robin pointer; r_last resets to BVH
  // so FB wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_payload <= '0;
      r_src     <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_load) begin
      r_payload <= r_mem[w_grant][r_rd_ptr[w_grant]];
      r_src     <= w_grant;
      r_last    <= w_grant;
    end
  end

  assign bus.fb_ready  = r_ready[0];
  assign bus.bvh_ready = r_ready[1];
  assign bus.mc_valid  = (r_state == S_HOLD);
  assign bus.mc_addr   = r_payload[ENT_W-1 -: ADDR_W];
  assign bus.mc_data   = r_payload[MASK_W +: DATA_W];
  assign bus.mc_mask   = r_payload[MASK_W-1:0];
  assign bus.mc_src    = r_src;
  assign bus.fb_level  = r_level[0];
  assign bus.bvh_level = r_level[1];
  assign bus.idle      = ~(|w_nonempty) && (r_state == S_EMPTY);

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: reset checks, a hand-derived vector table,
// directed multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_mem_write_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int DEPTH  = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) bus ();

  mem_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } req_t;

  typedef struct {
    req_t req;
    logic src;
    int   cyc;
  } beat_t;

  typedef struct {
    logic              fv;
    logic [ADDR_W-1:0] fa;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic              rdy;
    logic              ev;
    logic              es;
    logic [ADDR_W-1:0] ea;
    int                efl;
    int                ebl;
    logic              eidle;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: two request queues plus the output slot contents.
  req_t  m_fb_q[$];
  req_t  m_bvh_q[$];
  logic  m_valid;
  req_t  m_slot;
  logic  m_src;
  logic  m_last;
  logic  m_fb_ready;
  logic  m_bvh_ready;
  beat_t dut_log[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
    return {4{5'b0, a}};
  endfunction

  task automatic model_reset();
    m_fb_q.delete();
    m_bvh_q.delete();
    m_valid     = 1'b0;
    m_slot      = '{addr: '0, data: '0, mask: '0};
    m_src       = 1'b0;
    m_last      = 1'b1;
    m_fb_ready  = 1'b0;
    m_bvh_ready = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs as driven now.
  task automatic model_step();
    req_t fb_in, bvh_in, popped;
    logic push_fb, push_bvh, ne_fb, ne_bvh, grant;
    fb_in    = '{addr: bus.fb_addr, data: bus.fb_data, mask: bus.fb_mask};
    bvh_in   = '{addr: bus.bvh_addr, data: bus.bvh_data, mask: bus.bvh_mask};
    push_fb  = bus.fb_valid && m_fb_ready;
    push_bvh = bus.bvh_valid && m_bvh_ready;
    ne_fb    = (m_fb_q.size() > 0);
    ne_bvh   = (m_bvh_q.size() > 0);
    if ((!m_valid || bus.mc_ready) && (ne_fb || ne_bvh)) begin
      grant = (ne_fb && ne_bvh) ? !m_last : ne_bvh;
      if (grant) popped = m_bvh_q.pop_front();
      else       popped = m_fb_q.pop_front();
      m_slot  = popped;
      m_src   = grant;
      m_last  = grant;
      m_valid = 1'b1;
    end else if (bus.mc_ready) begin
      m_valid = 1'b0;
    end
    if (push_fb)  m_fb_q.push_back(fb_in);
    if (push_bvh) m_bvh_q.push_back(bvh_in);
    m_fb_ready  = (m_fb_q.size() < DEPTH);
    m_bvh_ready = (m_bvh_q.size() < DEPTH);
  endtask

  task automatic compare_all();
    check("mc_valid", bus.mc_valid, m_valid);
    if (m_valid) begin
      check("mc_addr", bus.mc_addr, m_slot.addr);
      check("mc_data", bus.mc_data, m_slot.data);
      check("mc_mask", bus.mc_mask, m_slot.mask);
      check("mc_src", bus.mc_src, m_src);
    end
    check("fb_level", bus.fb_level, m_fb_q.size());
    check("bvh_level", bus.bvh_level, m_bvh_q.size());
    check("fb_ready", bus.fb_ready, m_fb_ready);
    check("bvh_ready", bus.bvh_ready, m_bvh_ready);
    check("idle", bus.idle, (m_fb_q.size() == 0) && (m_bvh_q.size() == 0) && !m_valid);
  endtask

  // Called at a falling edge with inputs already set: logs any accepted beat,
  // advances the model, crosses one rising edge and compares at the next fall.
  task automatic cycle();
    beat_t b;
    if (resetn && bus.mc_valid && bus.mc_ready) begin
      b.req.addr = bus.mc_addr;
      b.req.data = bus.mc_data;
      b.req.mask = bus.mc_mask;
      b.src      = bus.mc_src;
      b.cyc      = cyc;
      dut_log.push_back(b);
    end
    if (resetn) model_step();
    else        model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (resetn) compare_all();
  endtask

  task automatic clear_inputs();
    bus.fb_valid  = 1'b0;
    bus.fb_addr   = '0;
    bus.fb_data   = '0;
    bus.fb_mask   = '0;
    bus.bvh_valid = 1'b0;
    bus.bvh_addr  = '0;
    bus.bvh_data  = '0;
    bus.bvh_mask  = '0;
  endtask

  task automatic apply_reset(input int n);
    clear_inputs();
    resetn = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    resetn = 1'b1;
    cycle();
  endtask

  task automatic check_log(input string name, input int n, input logic src_alt, input logic src_fixed,
                           input logic [ADDR_W-1:0] base0, input logic [ADDR_W-1:0] base1);
    logic                exp_src;
    logic [ADDR_W-1:0]   exp_addr;
    check({name, "_beats"}, dut_log.size(), n);
    for (int j = 0; j < n && j < dut_log.size(); j++) begin
      exp_src  = src_alt ? 1'(j % 2) : src_fixed;
      exp_addr = src_alt ? ((j % 2) ? base1 : base0) + ADDR_W'(j / 2) : base0 + ADDR_W'(j);
      check({name, "_src"}, dut_log[j].src, exp_src);
      check({name, "_addr"}, dut_log[j].req.addr, exp_addr);
      check({name, "_gap"}, dut_log[j].cyc - dut_log[0].cyc, j);
    end
  endtask

  vec_t vecs[12];
  int   accepted;

  initial begin
    clear_inputs();
    bus.mc_ready = 1'b0;
    model_reset();

    // Reset held 5 cycles with a framebuffer request pending.
    @(negedge clk);
    bus.fb_valid = 1'b1;
    bus.fb_addr  = 27'h55;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rst_mc_valid", bus.mc_valid, 1'b0);
      check("rst_mc_addr", bus.mc_addr, '0);
      check("rst_fb_level", bus.fb_level, 0);
      check("rst_fb_ready", bus.fb_ready, 1'b0);
      check("rst_bvh_ready", bus.bvh_ready, 1'b0);
      check("rst_idle", bus.idle, 1'b1);
    end
    resetn = 1'b1;
    #1;
    check("rel_fb_ready_pre", bus.fb_ready, 1'b0);
    cycle();
    check("rel_fb_ready", bus.fb_ready, 1'b1);
    check("rel_bvh_ready", bus.bvh_ready, 1'b1);
    check("rel_no_push", bus.fb_level, 0);
    clear_inputs();

    // Vector table, hand-derived from a fresh reset (FB wins the first tie).
    vecs[0]  = '{1, 'h10, 0, 'h00, 1,  0, 0, 'h00, 1, 0, 0};
    vecs[1]  = '{1, 'h11, 1, 'h20, 1,  1, 0, 'h10, 1, 1, 0};
    vecs[2]  = '{0, 'h00, 0, 'h00, 0,  1, 0, 'h10, 1, 1, 0};
    vecs[3]  = '{0, 'h00, 0, 'h00, 1,  1, 1, 'h20, 1, 0, 0};
    vecs[4]  = '{0, 'h00, 1, 'h21, 1,  1, 0, 'h11, 0, 1, 0};
    vecs[5]  = '{0, 'h00, 0, 'h00, 1,  1, 1, 'h21, 0, 0, 0};
    vecs[6]  = '{0, 'h00, 0, 'h00, 1,  0, 0, 'h00, 0, 0, 1};
    vecs[7]  = '{1, 'h12, 1, 'h22, 0,  0, 0, 'h00, 1, 1, 0};
    vecs[8]  = '{0, 'h00, 0, 'h00, 0,  1, 0, 'h12, 0, 1, 0};
    vecs[9]  = '{0, 'h00, 0, 'h00, 0,  1, 0, 'h12, 0, 1, 0};
    vecs[10] = '{0, 'h00, 0, 'h00, 1,  1, 1, 'h22, 0, 0, 0};
    vecs[11] = '{0, 'h00, 0, 'h00, 1,  0, 0, 'h00, 0, 0, 1};
    for (int i = 0; i < 12; i++) begin
      bus.fb_valid  = vecs[i].fv;
      bus.fb_addr   = vecs[i].fa;
      bus.fb_data   = mk_data(vecs[i].fa);
      bus.fb_mask   = '1;
      bus.bvh_valid = vecs[i].bv;
      bus.bvh_addr  = vecs[i].ba;
      bus.bvh_data  = mk_data(vecs[i].ba);
      bus.bvh_mask  = '1;
      bus.mc_ready  = vecs[i].rdy;
      cycle();
      check("vec_mc_valid", bus.mc_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check("vec_mc_src", bus.mc_src, vecs[i].es);
        check("vec_mc_addr", bus.mc_addr, vecs[i].ea);
      end
      check("vec_fb_level", bus.fb_level, vecs[i].efl);
      check("vec_bvh_level", bus.bvh_level, vecs[i].ebl);
      check("vec_idle", bus.idle, vecs[i].eidle);
    end
    clear_inputs();

    // Single write: on the port two edges after the push, for one cycle.
    bus.mc_ready = 1'b1;
    bus.fb_valid = 1'b1;
    bus.fb_addr  = 27'h0000100;
    bus.fb_data  = {16{8'hA5}};
    bus.fb_mask  = '1;
    cycle();
    clear_inputs();
    check("sw_valid_k", bus.mc_valid, 1'b0);
    cycle();
    check("sw_valid_k1", bus.mc_valid, 1'b1);
    check("sw_addr", bus.mc_addr, 27'h0000100);
    check("sw_data", bus.mc_data, {16{8'hA5}});
    check("sw_mask", bus.mc_mask, {MASK_W{1'b1}});
    check("sw_src", bus.mc_src, 1'b0);
    cycle();
    check("sw_valid_k2", bus.mc_valid, 1'b0);
    check("sw_idle", bus.idle, 1'b1);

    // Tie arbitration from a fresh reset.
    apply_reset(2);
    dut_log.delete();
    bus.mc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.fb_valid  = 1'b1;
      bus.fb_addr   = ADDR_W'(i);
      bus.fb_data   = mk_data(ADDR_W'(i));
      bus.bvh_valid = 1'b1;
      bus.bvh_addr  = ADDR_W'(32'h100 + i);
      bus.bvh_data  = mk_data(ADDR_W'(32'h100 + i));
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 14; i++) cycle();
    check_log("tie", 8, 1'b1, 1'b0, 27'h0, 27'h100);

    // Backpressure: 8 FIFO entries plus the slot absorb 9 of 12 offers.
    apply_reset(2);
    dut_log.delete();
    bus.mc_ready = 1'b0;
    accepted     = 0;
    for (int i = 0; i < 12; i++) begin
      bus.fb_valid = 1'b1;
      bus.fb_addr  = ADDR_W'(32'h200 + accepted);
      bus.fb_data  = mk_data(bus.fb_addr);
      bus.fb_mask  = '1;
      if (bus.fb_ready) accepted++;
      cycle();
      if (i > 0) check("bp_stable_addr", bus.mc_addr, 27'h200);
    end
    clear_inputs();
    check("bp_accepted", accepted, 9);
    check("bp_fb_level", bus.fb_level, 8);
    check("bp_fb_ready", bus.fb_ready, 1'b0);
    check("bp_mc_valid", bus.mc_valid, 1'b1);
    bus.mc_ready = 1'b1;
    cycle();
    check("bp_ready_rise", bus.fb_ready, 1'b1);
    check("bp_level_after_pop", bus.fb_level, 7);
    for (int i = 0; i < 12; i++) cycle();
    check_log("bp", 9, 1'b0, 1'b0, 27'h200, 27'h0);

    // BVH streaming: 20 back-to-back requests, no bubbles.
    dut_log.delete();
    bus.mc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("st_bvh_ready", bus.bvh_ready, 1'b1);
      bus.bvh_valid = 1'b1;
      bus.bvh_addr  = ADDR_W'(32'h300 + i);
      bus.bvh_data  = mk_data(bus.bvh_addr);
      bus.bvh_mask  = MASK_W'(i);
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) cycle();
    check_log("st", 20, 1'b0, 1'b1, 27'h300, 27'h0);

    // Mid-operation reset with 5 FB + 3 BVH requests queued.
    bus.mc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.fb_valid  = 1'b1;
      bus.fb_addr   = ADDR_W'(32'h400 + i);
      bus.bvh_valid = (i < 3);
      bus.bvh_addr  = ADDR_W'(32'h500 + i);
      cycle();
    end
    clear_inputs();
    cycle();
    check("mr_mc_valid_pre", bus.mc_valid, 1'b1);
    resetn = 1'b0;
    #1;
    check("mr_mc_valid", bus.mc_valid, 1'b0);
    check("mr_fb_level", bus.fb_level, 0);
    check("mr_bvh_level", bus.bvh_level, 0);
    check("mr_idle", bus.idle, 1'b1);
    cycle();
    resetn       = 1'b1;
    bus.mc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("mr_no_stale", bus.mc_valid, 1'b0);
    end

    // Randomized traffic in phases of differing controller backpressure.
    for (int ph = 0; ph < 6; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 70 : 100);
      for (int i = 0; i < 400; i++) begin
        bus.fb_valid  = ($urandom_range(0, 99) < 60);
        bus.fb_addr   = ADDR_W'($urandom);
        bus.fb_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.fb_mask   = MASK_W'($urandom);
        bus.bvh_valid = ($urandom_range(0, 99) < 60);
        bus.bvh_addr  = ADDR_W'($urandom);
        bus.bvh_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.bvh_mask  = MASK_W'($urandom);
        bus.mc_ready  = ($urandom_range(0, 99) < rdy_pct);
        cycle();
      end
    end
    clear_inputs();
    bus.mc_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) cycle();
    check("drain_idle", bus.idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
- Merges the two memory write streams, BVH builder and framebuffer writer, into the single write-request port of the memory controller.
- Each source has its own FIFO with valid/ready backpressure.
- A round-robin arbiter drives one registered output slot with a valid/ready handshake to the controller.
- Runs in the renderer clock domain; the memory controller owns the clock crossing.

Parameters:
ADDR_W, 27, write address width (DDR2 byte address)
DATA_W, 128, write data width
MASK_W, DATA_W/8, byte-enable width (1 = byte written)
DEPTH, 8, entries per source FIFO (power of two, >=2)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous assert, active-low
fb_valid  in  1  framebuffer write request valid
fb_ready  out  1  framebuffer FIFO can accept
fb_addr  in  ADDR_W  framebuffer write address
fb_data  in  DATA_W  framebuffer write data
fb_mask  in  MASK_W  framebuffer byte enables
bvh_valid, bvh_ready, bvh_addr, bvh_data, bvh_mask  same as fb_*, for the BVH source
mc_valid  out  1  request presented to memory controller
mc_ready  in  1  memory controller accepts request
mc_addr  out  ADDR_W  granted address
mc_data  out  DATA_W  granted data
mc_mask  out  MASK_W  granted byte enables
mc_src  out  1  source of current request: 0 = FB, 1 = BVH
fb_level  out  $clog2(DEPTH+1)  FB FIFO occupancy
bvh_level  out  $clog2(DEPTH+1)  BVH FIFO occupancy
idle  out  1  both FIFOs empty and mc_valid low

Behaviour:
- Reset: one clock `clk`; reset `resetn` is asynchronous, active-low.
  - While resetn is low: all queued entries are discarded. mc_valid=0, mc_addr/data/mask=0, mc_src=0, levels=0, fb_ready=bvh_ready=0, idle=1.
  - The round-robin pointer resets so FB wins the first tie.
  - fb_ready and bvh_ready rise on the first clk edge after resetn deasserts.
- Input acceptance:
  - An entry is pushed at a rising edge when x_valid && x_ready.
  - x_ready is registered: next value = (next level < DEPTH). It has no combinational path from mc_ready.
  - A full FIFO therefore refuses a push in the same cycle a pop frees a slot. ready rises one cycle later.
  - Per-source order is preserved. No ordering is guaranteed between sources, and no address-hazard checking is done.
- Output slot, two states:
  - EMPTY: mc_valid=0.
  - HOLD: mc_valid=1, payload held stable until mc_ready.
  - The slot loads at an edge when (EMPTY or mc_ready) and at least one FIFO is non-empty.
  - On load it pops the granted FIFO and goes to or stays in HOLD.
  - If mc_ready is high while in HOLD and both FIFOs are empty, the slot goes to EMPTY.
  - mc_valid never drops without mc_ready, and the payload never changes while mc_valid && !mc_ready.
- Arbitration:
  - Only one FIFO non-empty: it is granted, with no bubble cycles.
  - Both non-empty: the source not granted last time wins; the pointer updates on each load.
  - mc_src is registered with the payload.
- Latency and throughput:
  - With everything empty and mc_ready=1, a request accepted at edge k is on mc_* after edge k+1. mc_valid is high during the cycle after that, for one cycle if nothing follows.
  - Sustained throughput is 1 request/cycle while mc_ready=1.
- Capacity: each source holds DEPTH FIFO entries. One more entry may sit in the output slot.
- Level counters:
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
  - Levels never exceed DEPTH or go below 0.
- Mid-operation reset: asserting resetn discards FIFOs and the output slot immediately. No stale request appears after release.

Test Plan:
- Reset: hold resetn low 5 cycles with fb_valid=1 -> mc_valid=0, levels=0, readies=0, idle=1. Release -> fb_ready=bvh_ready=1 after first edge.
- Single write: fb_addr=0x0000100, fb_data=0xA5A5..A5, fb_mask=all ones, mc_ready=1 -> mc_valid high exactly 1 cycle, 2 edges after the push. Payload matches, mc_src=0, idle returns to 1.
- Tie arbitration: FB pushes addr 0..3 and BVH pushes addr 0x100..0x103 on the same 4 cycles, mc_ready=1 -> output order is FB0,BVH100,FB1,BVH101,... : 8 beats on consecutive cycles, mc_src alternating 0,1.
- Backpressure: mc_ready=0, FB offers 12 requests -> exactly 9 accepted (8 FIFO + 1 slot), fb_level=8, fb_ready=0, mc_* stable. Then mc_ready=1 -> 9 beats drain in push order, fb_ready rises one cycle after first pop.
- Single-source streaming: only BVH pushes 20 requests back-to-back, mc_ready=1 -> 20 consecutive mc_valid cycles with no gaps, all mc_src=1.
- Reset mid-operation: 5 FB + 3 BVH queued, mc_ready=0, pulse resetn low 1 cycle -> mc_valid drops immediately, levels=0. After release with no new input, mc_valid stays 0 for 20 cycles.
